// File: rtl/palette_pkg.sv
// Shared widths, CPU arbiter state encoding and the palette word decoder
// used by the palette video output stage.
package palette_pkg;

    localparam int PAL_AW = 13;
    localparam int PAL_DW = 16;
    localparam int RGB_W  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } cpu_state_t;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    // Bit 15 is an inverted common LSB, bits 14..12 are per-channel second LSBs.
    function automatic rgb_t pal_decode(input logic [PAL_DW-1:0] word,
                                        input logic dark_shadow);
        rgb_t c;
        c.r = {word[11:8], word[14], ~word[15]};
        c.g = {word[7:4],  word[13], ~word[15]};
        c.b = {word[3:0],  word[12], ~word[15]};
        if (dark_shadow) begin
            c.r = {1'b0, c.r[RGB_W-1:1]};
            c.g = {1'b0, c.g[RGB_W-1:1]};
            c.b = {1'b0, c.b[RGB_W-1:1]};
        end
        return c;
    endfunction

endpackage

// File: rtl/palette_video_out_decode.sv
// Combinational palette word to RGB conversion with shadow and blanking applied;
// the output register lives in the parent.
module palette_decode
    import palette_pkg::*;
#(
    parameter bit BLANK_BLACK = 1'b1,
    parameter bit SHADOW_EN   = 1'b1
) (
    input  logic [PAL_DW-1:0] word,
    input  logic              blank,
    input  logic              shadow,
    output rgb_t              rgb
);

    logic [3*RGB_W-1:0] raw_flat;
    logic [3*RGB_W-1:0] out_flat;
    logic               force_black;

    assign raw_flat    = pal_decode(word, SHADOW_EN && shadow);
    assign force_black = BLANK_BLACK && blank;

    // Blanking overrides whatever shadow did to each channel.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign out_flat[gi*RGB_W +: RGB_W] = force_black ? '0 : raw_flat[gi*RGB_W +: RGB_W];
        end
    endgenerate

    assign rgb = out_flat;

endmodule

// File: rtl/palette_video_out.sv
// Palette RAM consumer: per-pixel colour fetch and decode to 6-bit RGB, plus
// arbitration of the single RAM port between video fetches and buffered CPU accesses.
module palette_video_out
    import palette_pkg::*;
#(
    parameter bit BLANK_BLACK = 1'b1,
    parameter bit SHADOW_EN   = 1'b1
) (
    input  logic              CLK_24M,
    input  logic              RESET,
    input  logic              PIXEL_CE,
    input  logic [11:0]       PIX_INDEX,
    input  logic              PALBANK,
    input  logic              BLANK,
    input  logic              SHADOW,
    input  logic              CPU_REQ,
    input  logic              CPU_RW,
    input  logic [PAL_AW-1:0] CPU_ADDR,
    input  logic [PAL_DW-1:0] CPU_WDATA,
    output logic              CPU_BUSY,
    output logic              CPU_ACK,
    output logic [PAL_DW-1:0] CPU_RDATA,
    output logic [PAL_AW-1:0] PAL_ADDR,
    output logic [PAL_DW-1:0] PAL_WDATA,
    output logic              PAL_nWE,
    input  logic [PAL_DW-1:0] PAL_RDATA,
    output logic [RGB_W-1:0]  R,
    output logic [RGB_W-1:0]  G,
    output logic [RGB_W-1:0]  B
);

    cpu_state_t        state_reg;
    logic              cpu_rw_reg;
    logic [PAL_AW-1:0] cpu_addr_reg;
    logic [PAL_DW-1:0] cpu_wdata_reg;
    logic              busy_reg;
    logic              ack_reg;
    logic [PAL_DW-1:0] rdata_reg;

    logic [PAL_AW-1:0] pal_addr_reg;
    logic [PAL_AW-1:0] pal_addr_next;
    logic              pal_nwe_next;

    logic              ce_d1_reg;
    logic              blank_d1_reg;
    logic              shadow_d1_reg;
    rgb_t              rgb_reg;
    rgb_t              rgb_decoded;

    // RAM port mux: the pixel slot always owns the port; the CPU issues only on
    // a free clock while pending. Otherwise the last address is simply held.
    always_comb begin
        pal_addr_next = pal_addr_reg;
        pal_nwe_next  = 1'b1;
        if (!RESET) begin
            if (PIXEL_CE) begin
                pal_addr_next = {PALBANK, PIX_INDEX};
            end else if (state_reg == PEND) begin
                pal_addr_next = cpu_addr_reg;
                pal_nwe_next  = cpu_rw_reg;
            end
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            pal_addr_reg <= '0;
        end else begin
            pal_addr_reg <= pal_addr_next;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state_reg     <= IDLE;
            cpu_rw_reg    <= 1'b1;
            cpu_addr_reg  <= '0;
            cpu_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (CPU_REQ) begin
                        cpu_rw_reg   <= CPU_RW;
                        cpu_addr_reg <= CPU_ADDR;
                        if (!CPU_RW) begin
                            cpu_wdata_reg <= CPU_WDATA;
                        end
                        busy_reg  <= 1'b1;
                        state_reg <= PEND;
                    end
                end
                PEND: begin
                    if (!PIXEL_CE) begin
                        if (cpu_rw_reg) begin
                            state_reg <= RDWAIT;
                        end else begin
                            busy_reg  <= 1'b0;
                            ack_reg   <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                RDWAIT: begin
                    // Data for the address issued last clock; a pixel fetch now cannot disturb it.
                    rdata_reg <= PAL_RDATA;
                    busy_reg  <= 1'b0;
                    ack_reg   <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    palette_decode #(
        .BLANK_BLACK (BLANK_BLACK),
        .SHADOW_EN   (SHADOW_EN)
    ) u_decode (
        .word   (PAL_RDATA),
        .blank  (blank_d1_reg),
        .shadow (shadow_d1_reg),
        .rgb    (rgb_decoded)
    );

    // Blank and shadow travel alongside the fetch so they match the returned word.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            ce_d1_reg     <= 1'b0;
            blank_d1_reg  <= 1'b0;
            shadow_d1_reg <= 1'b0;
            rgb_reg       <= '0;
        end else begin
            ce_d1_reg <= PIXEL_CE;
            if (PIXEL_CE) begin
                blank_d1_reg  <= BLANK;
                shadow_d1_reg <= SHADOW;
            end
            if (ce_d1_reg) begin
                rgb_reg <= rgb_decoded;
            end
        end
    end

    assign PAL_ADDR  = pal_addr_next;
    assign PAL_nWE   = pal_nwe_next;
    assign PAL_WDATA = cpu_wdata_reg;
    assign CPU_BUSY  = busy_reg;
    assign CPU_ACK   = ack_reg;
    assign CPU_RDATA = rdata_reg;
    assign R         = rgb_reg.r;
    assign G         = rgb_reg.g;
    assign B         = rgb_reg.b;

endmodule

// File: tb/tb_palette_video_out.sv
// Bench for palette_video_out: palette RAM model, cycle-level reference model of
// the video/CPU port behaviour, and directed cases with literal expectations.
module tb_palette_video_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_ce = 1'b0;
    logic [11:0] pix_index = '0;
    logic        palbank = 1'b0;
    logic        blank = 1'b0;
    logic        shadow = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [12:0] pal_addr;
    logic [15:0] pal_wdata;
    logic        pal_nwe;
    logic [15:0] pal_rdata = '0;
    logic [5:0]  r, g, b;

    palette_video_out dut (
        .CLK_24M   (clk),
        .RESET     (reset),
        .PIXEL_CE  (pixel_ce),
        .PIX_INDEX (pix_index),
        .PALBANK   (palbank),
        .BLANK     (blank),
        .SHADOW    (shadow),
        .CPU_REQ   (cpu_req),
        .CPU_RW    (cpu_rw),
        .CPU_ADDR  (cpu_addr),
        .CPU_WDATA (cpu_wdata),
        .CPU_BUSY  (cpu_busy),
        .CPU_ACK   (cpu_ack),
        .CPU_RDATA (cpu_rdata),
        .PAL_ADDR  (pal_addr),
        .PAL_WDATA (pal_wdata),
        .PAL_nWE   (pal_nwe),
        .PAL_RDATA (pal_rdata),
        .R         (r),
        .G         (g),
        .B         (b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous palette RAM with one clock of read latency.
    logic [15:0] ram     [8192];
    logic [15:0] ref_mem [8192];
    always @(posedge clk) begin
        if (pal_nwe === 1'b0) ram[pal_addr] <= pal_wdata;
        pal_rdata <= ram[pal_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] model_rgb(input logic [15:0] w, input logic bl, input logic sh);
        int lo, rr, gg, bb;
        lo = w[15] ? 0 : 1;
        rr = int'(w[11:8]) * 4 + int'(w[14]) * 2 + lo;
        gg = int'(w[7:4])  * 4 + int'(w[13]) * 2 + lo;
        bb = int'(w[3:0])  * 4 + int'(w[12]) * 2 + lo;
        if (bl) begin
            rr = 0; gg = 0; bb = 0;
        end else if (sh) begin
            rr = rr / 2; gg = gg / 2; bb = bb / 2;
        end
        return {rr[5:0], gg[5:0], bb[5:0]};
    endfunction

    typedef struct {
        int          due;
        logic [17:0] rgb;
    } rgb_exp_t;
    rgb_exp_t rgb_q[$];

    // Reference model: one outstanding CPU access, issued on the first clock after
    // the request without a pixel strobe; ack 1 clock after a write issue, 2 after a read.
    bit          chk_en = 1'b0;
    logic [17:0] exp_rgb = '0;
    logic [15:0] exp_rdata = '0;
    bit          pend = 1'b0;
    bit          pend_issued = 1'b0;
    bit          pend_rw = 1'b1;
    logic [12:0] pend_addr = '0;
    logic [15:0] pend_wdata = '0;
    logic [15:0] pend_val = '0;
    int          pend_req_cyc = 0;
    int          ack_due = 0;

    always @(negedge clk) begin : cmp
        int c;
        bit issue_now, ack_now, busy_exp;
        if (chk_en) begin
            c = cyc;
            while (rgb_q.size() > 0 && rgb_q[0].due <= c) begin
                exp_rgb = rgb_q[0].rgb;
                void'(rgb_q.pop_front());
            end
            issue_now = pend && !pend_issued && (c > pend_req_cyc) && !pixel_ce && !reset;
            if (issue_now) begin
                pend_issued = 1'b1;
                ack_due     = c + (pend_rw ? 2 : 1);
                pend_val    = ref_mem[pend_addr];
                if (!pend_rw) ref_mem[pend_addr] = pend_wdata;
            end
            ack_now  = pend && pend_issued && (c == ack_due);
            busy_exp = pend && (c > pend_req_cyc) && !ack_now;
            if (ack_now && pend_rw) exp_rdata = pend_val;

            chk("rgb", {r, g, b}, exp_rgb);
            chk("busy", cpu_busy, busy_exp);
            chk("ack", cpu_ack, ack_now);
            chk("rdata", cpu_rdata, exp_rdata);
            if (!reset && pixel_ce) begin
                chk("video_addr", pal_addr, {palbank, pix_index});
                chk("video_nwe", pal_nwe, 1'b1);
            end else if (issue_now) begin
                chk("cpu_addr", pal_addr, pend_addr);
                chk("cpu_nwe", pal_nwe, pend_rw);
                if (!pend_rw) chk("cpu_wdata", pal_wdata, pend_wdata);
            end else begin
                chk("idle_nwe", pal_nwe, 1'b1);
            end

            if (cpu_req && !reset && !pend) begin
                pend         = 1'b1;
                pend_issued  = 1'b0;
                pend_rw      = cpu_rw;
                pend_addr    = cpu_addr;
                pend_wdata   = cpu_wdata;
                pend_req_cyc = c;
            end
            if (ack_now) pend = 1'b0;
            if (reset) begin
                pend      = 1'b0;
                exp_rgb   = '0;
                exp_rdata = '0;
                rgb_q.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic bank, input logic [11:0] idx, input logic bl, input logic sh);
        rgb_exp_t e;
        pixel_ce  = 1'b1;
        palbank   = bank;
        pix_index = idx;
        blank     = bl;
        shadow    = sh;
        e.due = cyc + 2;
        e.rgb = model_rgb(ref_mem[{bank, idx}], bl, sh);
        rgb_q.push_back(e);
        $display("cycle %0d pixel bank=%0d idx=%03h blank=%0d shadow=%0d", cyc, bank, idx, bl, sh);
    endtask

    task automatic pixel_and_wait(input logic bank, input logic [11:0] idx, input logic bl, input logic sh);
        tick();
        drive_pixel(bank, idx, bl, sh);
        tick();
        pixel_ce = 1'b0;
        tick();
        #3;
    endtask

    task automatic cpu_drive(input logic rw, input logic [12:0] addr, input logic [15:0] wd);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wd;
        $display("cycle %0d cpu %s addr=%04h wdata=%04h", cyc, rw ? "read" : "write", addr, wd);
    endtask

    // Returns clocks from request to ack, or -1 if none arrives within the limit.
    task automatic wait_ack(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            cpu_req = 1'b0;
            #3;
            if (cpu_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, acks, addr_seen;
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 16'((i * 40503) ^ 16'h5A5A);
            ref_mem[i] = ram[i];
        end
        ram[13'h0123] = 16'h8F00; ref_mem[13'h0123] = 16'h8F00;
        ram[13'h0005] = 16'hBEEF; ref_mem[13'h0005] = 16'hBEEF;
        ram[13'h0777] = 16'h7FFF; ref_mem[13'h0777] = 16'h7FFF;
        ram[13'h1ABC] = 16'h0F0F; ref_mem[13'h1ABC] = 16'h0F0F;

        tick(); tick(); tick();
        chk_en = 1'b1;
        reset  = 1'b0;
        tick();
        #3;
        chk("rst_r", r, 6'h00);
        chk("rst_g", g, 6'h00);
        chk("rst_b", b, 6'h00);
        chk("rst_nwe", pal_nwe, 1'b1);
        chk("rst_pal_addr", pal_addr, 13'h0000);
        chk("rst_pal_wdata", pal_wdata, 16'h0000);
        chk("rst_busy", cpu_busy, 1'b0);
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_rdata", cpu_rdata, 16'h0000);

        // Fetch latency and decode of 0x8F00
        pixel_and_wait(1'b0, 12'h123, 1'b0, 1'b0);
        chk("t1_r", r, 6'h3C);
        chk("t1_g", g, 6'h00);
        chk("t1_b", b, 6'h00);

        // 0x7FFF plain, shadowed, blanked
        pixel_and_wait(1'b0, 12'h777, 1'b0, 1'b0);
        chk("t2_r", r, 6'h3F); chk("t2_g", g, 6'h3F); chk("t2_b", b, 6'h3F);
        pixel_and_wait(1'b0, 12'h777, 1'b0, 1'b1);
        chk("t2s_r", r, 6'h1F); chk("t2s_g", g, 6'h1F); chk("t2s_b", b, 6'h1F);
        pixel_and_wait(1'b0, 12'h777, 1'b1, 1'b1);
        chk("t2b_r", r, 6'h00); chk("t2b_g", g, 6'h00); chk("t2b_b", b, 6'h00);
        pixel_and_wait(1'b1, 12'h123, 1'b0, 1'b0);

        // CPU write requested the clock before a pixel fetch of the same word
        tick();
        cpu_drive(1'b0, 13'h1ABC, 16'h1234);
        tick();
        cpu_req = 1'b0;
        drive_pixel(1'b1, 12'hABC, 1'b0, 1'b0);
        tick();
        pixel_ce = 1'b0;
        #3;
        chk("t3_nwe_low", pal_nwe, 1'b0);
        chk("t3_addr", pal_addr, 13'h1ABC);
        chk("t3_wdata", pal_wdata, 16'h1234);
        tick();
        #3;
        chk("t3_nwe_high", pal_nwe, 1'b1);
        chk("t3_ack", cpu_ack, 1'b1);
        chk("t3_pre_r", r, 6'h3D);
        chk("t3_pre_g", g, 6'h01);
        chk("t3_pre_b", b, 6'h3D);
        tick();
        cpu_drive(1'b1, 13'h1ABC, 16'h0000);
        wait_ack(8, lat);
        chk("t3_rb_lat", lat, 3);
        chk("t3_rb_data", cpu_rdata, 16'h1234);
        pixel_and_wait(1'b1, 12'hABC, 1'b0, 1'b0);
        chk("t3_post_r", r, 6'h09);
        chk("t3_post_g", g, 6'h0D);
        chk("t3_post_b", b, 6'h13);

        // Uncontended read
        tick();
        cpu_drive(1'b1, 13'h0005, 16'h0000);
        wait_ack(8, lat);
        chk("t4_lat", lat, 3);
        chk("t4_data", cpu_rdata, 16'hBEEF);

        // Requests while busy and in the ack clock are dropped
        tick();
        cpu_drive(1'b1, 13'h0005, 16'h0000);
        acks = 0;
        addr_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1 || i == 3) cpu_drive(1'b0, 13'h1FFF, 16'hDEAD);
            else cpu_req = 1'b0;
            #3;
            if (cpu_ack === 1'b1) acks++;
            if (pal_addr === 13'h1FFF) addr_seen++;
        end
        chk("t5_acks", acks, 1);
        chk("t5_addr_seen", addr_seen, 0);
        chk("t5_mem", ram[13'h1FFF], ref_mem[13'h1FFF]);

        // Read delayed by a pixel strobe, with another strobe in the data-wait clock
        tick();
        cpu_drive(1'b1, 13'h0005, 16'h0000);
        tick();
        cpu_req = 1'b0;
        drive_pixel(1'b0, 12'h777, 1'b0, 1'b0);
        tick();
        pixel_ce = 1'b0;
        tick();
        drive_pixel(1'b0, 12'h123, 1'b0, 1'b1);
        tick();
        pixel_ce = 1'b0;
        #3;
        chk("t4b_ack", cpu_ack, 1'b1);
        chk("t4b_data", cpu_rdata, 16'hBEEF);
        pixel_and_wait(1'b1, 12'hABC, 1'b0, 1'b0);

        // Reset while waiting for read data
        tick();
        cpu_drive(1'b1, 13'h0123, 16'h0000);
        tick();
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        $display("cycle %0d reset asserted", cyc);
        tick();
        reset = 1'b0;
        #3;
        chk("t6_busy", cpu_busy, 1'b0);
        chk("t6_ack", cpu_ack, 1'b0);
        chk("t6_rgb", {r, g, b}, 18'h0);
        chk("t6_nwe", pal_nwe, 1'b1);
        tick();
        #3;
        chk("t6_ack_later", cpu_ack, 1'b0);
        pixel_and_wait(1'b0, 12'h123, 1'b0, 1'b0);
        chk("t6_pix_r", r, 6'h3C);
        tick();
        cpu_drive(1'b1, 13'h0777, 16'h0000);
        wait_ack(8, lat);
        chk("t6_rd_lat", lat, 3);
        chk("t6_rd_data", cpu_rdata, 16'h7FFF);

        tick(); tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
